// File: rtl/native_arbiter.sv
// Round-robin arbiter sharing one native register port (WEN/REN/RDATA/RVALID) among N_REQ requesters.
// Latency: WEN/REN one cycle after grant; REQ_DONE one cycle after WEN, or one cycle after RVALID for reads.
// Backpressure: requests are level-held until REQ_DONE; reads wait on RVALID (bounded when NATIVE_ARB_TIMEOUT_EN is defined).
`timescale 1ns/1ps

module native_arbiter #(
  parameter int N_REQ          = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_ARESETN,
  input  logic [N_REQ-1:0]              REQ_VALID,
  input  logic [N_REQ-1:0]              REQ_WRITE,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [N_REQ*DATA_WIDTH-1:0]   REQ_WDATA,
  output logic [N_REQ-1:0]              REQ_DONE,
  output logic [DATA_WIDTH-1:0]         REQ_RDATA,
  output logic                          REQ_ERR,
  output logic                          BUSY,
  output logic                          WEN,
  output logic [ADDR_WIDTH-1:0]         WADDR,
  output logic [DATA_WIDTH-1:0]         WDATA,
  output logic                          REN,
  output logic [ADDR_WIDTH-1:0]         RADDR,
  input  logic [DATA_WIDTH-1:0]         RDATA,
  input  logic                          RVALID
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       sel_idx;
  logic [IDX_W-1:0]       cand;
  logic                   sel_any;
  logic [N_REQ-1:0]       sel_oh;
  logic [N_REQ-1:0]       gnt_oh;
  logic                   cap_write;
  logic [ADDR_WIDTH-1:0]  addr_arr  [N_REQ];
  logic [DATA_WIDTH-1:0]  wdata_arr [N_REQ];

`ifdef NATIVE_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]       tmo_cnt;
`else
  // No read timeout in this build; a non-negative cycle count makes this constant 0.
  assign REQ_ERR = (TIMEOUT_CYCLES < 0);
`endif

  // Split the packed per-requester buses into indexable arrays.
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = REQ_ADDR[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = REQ_WDATA[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Pick the first requesting index at or above the pointer, wrapping; the lowest offset wins.
  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (REQ_VALID[cand]) begin
        sel_any = 1'b1;
        sel_idx = cand;
      end
    end
  end

  // One-hot form of the selected index, latched at grant to drive REQ_DONE later.
  always_comb begin
    sel_oh          = '0;
    sel_oh[sel_idx] = 1'b1;
  end

  // Access sequencer: every output is a register set on the transition into the state that shows it.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_oh    <= '0;
      cap_write <= 1'b0;
      REQ_DONE  <= '0;
      REQ_RDATA <= '0;
      BUSY      <= 1'b0;
      WEN       <= 1'b0;
      WADDR     <= '0;
      WDATA     <= '0;
      REN       <= 1'b0;
      RADDR     <= '0;
`ifdef NATIVE_ARB_TIMEOUT_EN
      REQ_ERR   <= 1'b0;
      tmo_cnt   <= '0;
`endif
    end else begin
      // Strobes are single-cycle unless a state below re-asserts them.
      WEN      <= 1'b0;
      REN      <= 1'b0;
      REQ_DONE <= '0;
      case (state)
        IDLE: begin
          if (sel_any) begin
            state     <= ISSUE;
            BUSY      <= 1'b1;
            gnt_oh    <= sel_oh;
            cap_write <= REQ_WRITE[sel_idx];
            ptr       <= (int'(sel_idx) == N_REQ - 1) ? '0 : sel_idx + 1'b1;
            // Address/data go straight into the port registers, which then hold until the next access of that kind.
            if (REQ_WRITE[sel_idx]) begin
              WEN   <= 1'b1;
              WADDR <= addr_arr[sel_idx];
              WDATA <= wdata_arr[sel_idx];
            end else begin
              REN   <= 1'b1;
              RADDR <= addr_arr[sel_idx];
            end
          end
        end
        ISSUE: begin
          if (cap_write) begin
            state    <= RESP;
            REQ_DONE <= gnt_oh;
`ifdef NATIVE_ARB_TIMEOUT_EN
            REQ_ERR  <= 1'b0;
`endif
          end else begin
            state    <= WAIT_RD;
`ifdef NATIVE_ARB_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
          end
        end
        WAIT_RD: begin
          // RVALID is only honoured here, and beats a timeout landing in the same cycle.
          if (RVALID) begin
            state     <= RESP;
            REQ_DONE  <= gnt_oh;
            REQ_RDATA <= RDATA;
`ifdef NATIVE_ARB_TIMEOUT_EN
            REQ_ERR   <= 1'b0;
          end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state     <= RESP;
            REQ_DONE  <= gnt_oh;
            REQ_RDATA <= '1;
            REQ_ERR   <= 1'b1;
          end else begin
            tmo_cnt   <= tmo_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          state <= IDLE;
          BUSY  <= 1'b0;
`ifdef NATIVE_ARB_TIMEOUT_EN
          REQ_ERR <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_native_arbiter.sv
// Scoreboard bench for native_arbiter with four requesters.
// Stimulus pushes expected WEN/REN/REQ_DONE events; a monitor pops and compares as the DUT emits them.
// Slave responses (RVALID/RDATA) are driven directly by the stimulus process.
`timescale 1ns/1ps

module tb_native_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_done;
  logic [DW-1:0]   req_rdata;
  logic            req_err;
  logic            busy;
  logic            wen;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic            ren;
  logic [AW-1:0]   raddr;
  logic [DW-1:0]   rdata;
  logic            rvalid;

  native_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)
  ) dut (
    .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
    .REQ_VALID(req_valid), .REQ_WRITE(req_write), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .REQ_DONE(req_done), .REQ_RDATA(req_rdata), .REQ_ERR(req_err), .BUSY(busy),
    .WEN(wen), .WADDR(waddr), .WDATA(wdata), .REN(ren), .RADDR(raddr),
    .RDATA(rdata), .RVALID(rvalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = WEN, 1 = REN, 2 = REQ_DONE. gap is cycles since the previous event (or since the request when from_req).
  typedef struct {
    int          kind;
    int          gap;
    bit          from_req;
    logic [31:0] a;
    logic [31:0] d;
    logic [N-1:0] done;
    logic        err;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad = 0;
  int   req_cyc = 0;
  int   last_evt = 0;
  int   obs_kind;
  exp_t e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_w(input int gap, input bit fr, input logic [31:0] a, input logic [31:0] d);
    expq.push_back('{kind: 0, gap: gap, from_req: fr, a: a, d: d, done: '0, err: 1'b0});
  endfunction

  function automatic void push_r(input int gap, input bit fr, input logic [31:0] a);
    expq.push_back('{kind: 1, gap: gap, from_req: fr, a: a, d: 32'h0, done: '0, err: 1'b0});
  endfunction

  function automatic void push_d(input int gap, input logic [N-1:0] m, input logic [31:0] d, input logic er);
    expq.push_back('{kind: 2, gap: gap, from_req: 1'b0, a: 32'h0, d: d, done: m, err: er});
  endfunction

  // Monitor: samples 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("wen_ren_exclusive", 32'(wen & ren), 32'h0);
      if (wen || ren || (|req_done)) begin
        obs_kind = (|req_done) ? 2 : (wen ? 0 : 1);
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: kind %0d done %b at cycle %0d, expected no event", obs_kind, req_done, cyc);
        end else begin
          e = expq.pop_front();
          chk("event_kind", 32'(obs_kind), 32'(e.kind));
          if (e.gap >= 0) chk("event_gap", 32'(cyc - (e.from_req ? req_cyc : last_evt)), 32'(e.gap));
          case (e.kind)
            0: begin
              chk("waddr", waddr, e.a);
              chk("wdata", wdata, e.d);
            end
            1: chk("raddr", raddr, e.a);
            default: begin
              chk("req_done", 32'(req_done), 32'(e.done));
              chk("req_rdata", req_rdata, e.d);
              chk("req_err", 32'(req_err), 32'(e.err));
            end
          endcase
        end
        last_evt = cyc;
      end
    end
  end

  task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_write[i]           = w;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
  endtask

  // Returns on the falling edge of the REN cycle.
  task automatic wait_ren();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = ren;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL wait_ren: REN not seen within 60 cycles, required within 60");
    end
  endtask

  // Returns on the falling edge of the cycle where any bit of m is set in REQ_DONE.
  task automatic wait_done(input logic [N-1:0] m);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = |(req_done & m);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL wait_done: REQ_DONE & %b not seen within 60 cycles", m);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    rdata     = '0;
    rvalid    = 1'b0;

    // Reset values
    #12;
    chk("rst_req_done", 32'(req_done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wen", 32'(wen), 32'h0);
    chk("rst_ren", 32'(ren), 32'h0);
    chk("rst_waddr", waddr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_raddr", raddr, 32'h0);
    chk("rst_req_rdata", req_rdata, 32'h0);
    chk("rst_req_err", 32'(req_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fairness: all four write continuously -> 0,1,2,3,0,1,2,3
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h100 + 32'(i), 32'hD0 + 32'(i));
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        push_w((r == 0 && i == 0) ? 1 : 2, (r == 0 && i == 0), 32'h100 + 32'(i), 32'hD0 + 32'(i));
        push_d(1, 4'(1 << i), 32'h0, 1'b0);
      end
    end
    req_valid = '1;
    req_cyc   = cyc;
    for (int n = 0; n < 2 * N; n++) wait_done('1);
    req_valid = '0;
    @(negedge clk);

    // Single write from requester 0
    set_req(0, 1'b1, 32'h10, 32'hCAFEBABE);
    push_w(1, 1'b1, 32'h10, 32'hCAFEBABE);
    push_d(1, 4'b0001, 32'h0, 1'b0);
    req_valid = 4'b0001;
    req_cyc   = cyc;
    @(negedge clk);
    chk("busy_issue", 32'(busy), 32'h1);
    wait_done(4'b0001);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'h0);

    // Single read from requester 1, RVALID three cycles after REN
    set_req(1, 1'b0, 32'h20, 32'h0);
    push_r(1, 1'b1, 32'h20);
    push_d(4, 4'b0010, 32'h12345678, 1'b0);
    req_valid = 4'b0010;
    req_cyc   = cyc;
    wait_ren();
    repeat (3) @(negedge clk);
    rvalid = 1'b1;
    rdata  = 32'h12345678;
    @(negedge clk);
    rvalid       = 1'b0;
    rdata        = 32'h0;
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("waddr_hold", waddr, 32'h10);
    chk("wdata_hold", wdata, 32'hCAFEBABE);

    // Spurious RVALID in IDLE and in the REN cycle, then the real one
    rvalid = 1'b1;
    rdata  = 32'hDEAD0001;
    @(negedge clk);
    rvalid = 1'b0;
    set_req(2, 1'b0, 32'h30, 32'h0);
    push_r(1, 1'b1, 32'h30);
    push_d(3, 4'b0100, 32'hA5A5A5A5, 1'b0);
    req_valid = 4'b0100;
    req_cyc   = cyc;
    wait_ren();
    rvalid = 1'b1;
    rdata  = 32'hDEAD0002;
    @(negedge clk);
    rvalid = 1'b0;
    @(negedge clk);
    rvalid = 1'b1;
    rdata  = 32'hA5A5A5A5;
    @(negedge clk);
    rvalid       = 1'b0;
    req_valid[2] = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while waiting for read data; pointer is 3 here and becomes 1 at this grant
    set_req(0, 1'b0, 32'h40, 32'h0);
    push_r(1, 1'b1, 32'h40);
    req_valid = 4'b0001;
    req_cyc   = cyc;
    wait_ren();
    repeat (2) @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_req_done", 32'(req_done), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rvalid = 1'b1;
    rdata  = 32'hBAD0BAD0;
    @(negedge clk);
    rvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("postrst_busy", 32'(busy), 32'h0);

    // After reset the pointer restarts at 0: requester 0 beats requester 2
    set_req(0, 1'b1, 32'h50, 32'h55);
    set_req(2, 1'b1, 32'h60, 32'h66);
    push_w(1, 1'b1, 32'h50, 32'h55);
    push_d(1, 4'b0001, 32'h0, 1'b0);
    push_w(2, 1'b0, 32'h60, 32'h66);
    push_d(1, 4'b0100, 32'h0, 1'b0);
    req_valid = 4'b0101;
    req_cyc   = cyc;
    wait_done(4'b0001);
    req_valid[0] = 1'b0;
    wait_done(4'b0100);
    req_valid[2] = 1'b0;

`ifdef NATIVE_ARB_TIMEOUT_EN
    // Read with no RVALID: error response 16 cycles into WAIT_RD
    set_req(3, 1'b0, 32'h70, 32'h0);
    push_r(1, 1'b1, 32'h70);
    push_d(17, 4'b1000, 32'hFFFFFFFF, 1'b1);
    req_valid = 4'b1000;
    req_cyc   = cyc;
    wait_done(4'b1000);
    req_valid[3] = 1'b0;
`endif

    for (int i = 0; i < 50 && expq.size() > 0; i++) @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 32'h0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
